// File: rtl/seq_mult.sv
// seq_mult: multi-cycle shift-add multiplier, signed or unsigned per operation.
// start/busy/done handshake; product z is registered and held until the next
// completion. Optional build macro SEQ_MULT_EARLY_EXIT_EN ends the iteration
// as soon as the remaining multiplier bits are all zero.
module seq_mult #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state, state_next;
   logic [PW-1:0]      mcand, mcand_next;
   logic [WIDTH-1:0]   mplier, mplier_next;
   logic [PW-1:0]      acc, acc_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               neg, neg_next;
   logic [PW-1:0]      z_next;
   logic               busy_next, done_next;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [PW-1:0]      acc_sum;
   logic               last_iter;

   // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1)
   always_comb begin
      a_abs = (is_signed && a[WIDTH-1]) ? WIDTH'(-a) : a;
      b_abs = (is_signed && b[WIDTH-1]) ? WIDTH'(-b) : b;
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         z      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         mcand  <= mcand_next;
         mplier <= mplier_next;
         acc    <= acc_next;
         cnt    <= cnt_next;
         neg    <= neg_next;
         z      <= z_next;
         busy   <= busy_next;
         done   <= done_next;
      end
   end

   // Next-state, iteration datapath and registered-output decode
   always_comb begin
      state_next  = state;
      mcand_next  = mcand;
      mplier_next = mplier;
      acc_next    = acc;
      cnt_next    = cnt;
      neg_next    = neg;
      z_next      = z;
      acc_sum     = mplier[0] ? (acc + mcand) : acc;
      last_iter   = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_next  = S_CALC;
               mcand_next  = PW'(a_abs);
               mplier_next = b_abs;
               acc_next    = '0;
               cnt_next    = '0;
               neg_next    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            end
         end
         S_CALC: begin
            acc_next    = acc_sum;
            mcand_next  = mcand << 1;
            mplier_next = mplier >> 1;
            cnt_next    = cnt + CNT_W'(1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
            last_iter   = (cnt_next == CNT_W'(WIDTH)) || (mplier_next == '0);
`else
            last_iter   = (cnt_next == CNT_W'(WIDTH));
`endif
            if (last_iter) begin
               state_next = S_DONE;
               z_next     = neg ? PW'(-acc_sum) : acc_sum;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      busy_next = (state_next == S_CALC);
      done_next = (state_next == S_DONE);
   end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised multi-cycle shift-add multiplier; next generation of the CPU's fixed 32-bit unsigned multiplier.
- Handles signed or unsigned operands, selected per operation.
- Uses a start/busy/done handshake instead of computing in one clock edge.
- Sits beside the ALU in the execute stage and serves MULT/MULTU. The pipeline stalls on busy and writes HI/LO from z on done.

Parameters:
- WIDTH, 32, operand width in bits (>= 2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, request; sampled only in IDLE.
- is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
- a, input, WIDTH, multiplicand; sampled with start.
- b, input, WIDTH, multiplier; sampled with start.
- busy, output, 1, high while state is CALC.
- done, output, 1, one-cycle pulse; z is valid from this cycle.
- z, output, 2*WIDTH, product; registered.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
  - On reset: state = IDLE, busy = 0, done = 0, z = 0, counter = 0, internal registers = 0.
- States:
  - IDLE: done = 0, busy = 0. If start = 1 at an edge, go to CALC and load operands.
  - CALC: busy = 1. Perform one iteration per edge.
  - DONE: done = 1 for exactly one cycle. Next edge goes to IDLE unconditionally. start in DONE is ignored.
- Load (edge that samples start):
  - mcand (2*WIDTH bits) = zero-extended |a|.
  - mplier (WIDTH bits) = |b|.
  - acc = 0, counter = 0.
  - neg = is_signed & (a[MSB] ^ b[MSB]).
  - |x| = x when is_signed = 0 or x[MSB] = 0; otherwise the two's-complement negation, taken as an unsigned WIDTH-bit value. -2^(WIDTH-1) therefore gives 2^(WIDTH-1) exactly.
- Iteration (each CALC edge):
  - If mplier[0] = 1, acc = acc + mcand (mod 2^(2*WIDTH)).
  - mcand <<= 1; mplier >>= 1; counter += 1.
- Termination:
  - On the edge where counter reaches WIDTH (i.e. the WIDTH-th iteration), go to DONE.
  - On that same edge, z = neg ? -(acc_final) : acc_final, where acc_final includes that edge's add.
- Latency: done is high in the cycle following the WIDTH-th edge after the start edge.
- Output stability:
  - z holds its value until the next DONE entry or reset.
  - z is not cleared by a new start; it changes only at completion.
- start while busy (CALC or DONE) is ignored and not queued. Operand changes during CALC have no effect.
- Reset mid-operation aborts immediately: state = IDLE, z = 0, no done pulse.
- Unsigned result is exact for all inputs, max (2^WIDTH-1)^2.
  - Signed result is exact two's complement in 2*WIDTH bits.
  - No overflow is possible in either mode.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN.
- Defined:
  - In CALC, go to DONE on the first edge where the post-shift mplier == 0, or the counter reaches WIDTH, whichever comes first. z is written on that edge.
  - At least one CALC iteration always occurs.
  - Latency = max(1, position of highest set bit of |b| + 1) edges.
  - b = 0 or b = 1 yields done one cycle after the first CALC edge.
- Not defined: fixed latency of WIDTH iterations for every operand; counter is the only termination condition.
- The product value is identical in both builds.

Test Plan:
- Unsigned max: WIDTH=32, is_signed=0, a=b=0xFFFFFFFF -> z=0xFFFFFFFE00000001. done pulses exactly once, 32 CALC edges after the start edge (feature off).
- Signed mixed sign: is_signed=1, a=0xFFFFFFFD (-3), b=5 -> z=0xFFFFFFFFFFFFFFF1. Then a=b=0xFFFFFFFF -> z=0x0000000000000001.
- Signed extremes: a=b=0x80000000, is_signed=1 -> z=0x4000000000000000. Same operands with is_signed=0 -> z=0x4000000000000000. a=0x80000000, b=1, signed -> z=0xFFFFFFFF80000000.
- Handshake:
  - Pulse start with a=7, b=6.
  - Re-assert start with a=2, b=2 at CALC edge 10.
  - Expect z=42 and a single done; busy=1 for exactly 32 cycles.
  - z stays 42 until the next completed operation.
- Reset mid-op: assert reset at CALC edge 15 of a=123, b=456 -> busy=0, done=0, z=0 immediately. A following start a=3, b=4 gives z=12 normally.
- Early exit (SEQ_MULT_EARLY_EXIT_EN defined):
  - b=1, a=9 -> z=9 with 1 CALC edge.
  - b=0x10, a=3 -> z=0x30 with 5 CALC edges.
  - b=0xFFFFFFFF, unsigned -> 32 edges.
